adder_result_stage_32_bit: RTL and testbench
============================================

ADDER_RESULT_STAGE_32_BIT -- requirements
Module: adder_result_stage_32_bit

Interface
REQ-001 Parameter WIDTH, default 32, result data width; SHALL be the only parameter.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock, all state updates on this edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream adder result valid.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 sum  input  WIDTH  adder sum.
REQ-008 cout  input  1  adder carry-out.
REQ-009 a_msb  input  1  MSB of operand a that produced sum.
REQ-010 b_msb  input  1  MSB of operand b that produced sum.
REQ-011 out_valid  output  1  head result available.
REQ-012 out_ready  input  1  downstream accepts head result.
REQ-013 out_sum  output  WIDTH  head result sum.
REQ-014 out_flags  output  4  head flags {C,V,N,Z}, bit3=C, bit0=Z.
REQ-015 result_count  output  16  number of results delivered downstream.
REQ-016 clr_sticky  input  1  clears ovf_sticky.
REQ-017 ovf_sticky  output  1  set once any accepted result had V=1.

Function
REQ-018 Input handshake SHALL occur on cycle where in_valid=1 and in_ready=1; output handshake where out_valid=1 and out_ready=1.
REQ-019 Stage SHALL be a 2-entry in-order buffer with fill states EMPTY, ONE, FULL.
REQ-020 Transitions: EMPTY-push->ONE; ONE-push only->FULL; ONE-pop only->EMPTY; ONE-push+pop->ONE; FULL-pop->ONE; no event->hold.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; a push while FULL SHALL be impossible and in_valid in FULL SHALL be ignored.
REQ-022 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY; latency from input handshake to out_valid SHALL be exactly 1 cycle when EMPTY.
REQ-023 out_sum/out_flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Flags SHALL be computed at input handshake and stored with the entry: Z=(sum==0), N=sum[WIDTH-1], C=cout, V=(a_msb==b_msb)&&(sum[WIDTH-1]!=a_msb).
REQ-025 Result order SHALL be preserved; no entry SHALL be dropped or duplicated.
REQ-026 result_count SHALL increment by 1 on each output handshake and wrap 0xFFFF->0x0000.
REQ-027 ovf_sticky SHALL set on an input handshake with V=1; clr_sticky=1 SHALL clear it; simultaneous set and clear SHALL leave it 1.
REQ-028 out_sum and out_flags SHALL be 0 when out_valid=0.

Reset
REQ-029 While rst=1 at a clock edge: state->EMPTY, entries discarded, out_valid=0, out_sum=0, out_flags=0, result_count=0, ovf_sticky=0.
REQ-030 in_ready SHALL be 1 in the cycle after reset; handshakes in a cycle with rst=1 SHALL have no effect.
REQ-031 Reset mid-operation (ONE or FULL) SHALL discard all entries with no output handshake counted.

Verification
REQ-032 Push sum=0x0025002B, cout=0, a_msb=0, b_msb=0, out_ready=1 -> next cycle out_valid=1, out_sum=0x0025002B, out_flags=4'b0000, then result_count=1.
REQ-033 Push sum=0x00000000, cout=1, a_msb=1, b_msb=0 -> out_flags=4'b1001 (C=1,Z=1), ovf_sticky stays 0.
REQ-034 Push sum=0x80000000, cout=0, a_msb=0, b_msb=0 -> out_flags=4'b0110 (V=1,N=1), ovf_sticky=1; assert clr_sticky with a further V=1 push same cycle -> ovf_sticky remains 1.
REQ-035 out_ready=0, push 0x1, 0x2, 0x3 -> in_ready=0 after second push, 0x3 not accepted; release out_ready -> 0x1 then 0x2 in order, result_count=2.
REQ-036 State FULL, assert rst one cycle -> out_valid=0, in_ready=1, result_count=0, ovf_sticky=0 next cycle.
REQ-037 Preload result_count=0xFFFF via 65535 handshakes, one more handshake -> result_count=0x0000.

Source files
------------

// File: rtl/adder_result_stage_32_bit.sv
// Two-entry in-order result buffer behind an adder: computes {C,V,N,Z} flags on
// intake, preserves order, counts delivered results and keeps a sticky overflow bit.
//
//   state   | meaning
//   --------+------------------------------------------------
//   S_EMPTY | no entries held; in_ready=1, out_valid=0
//   S_ONE   | one entry in slot 0; in_ready=1, out_valid=1
//   S_FULL  | slot 0 is head, slot 1 is next; in_ready=0
module adder_result_stage_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags,
  output logic [15:0]      result_count,
  input  logic             clr_sticky,
  output logic             ovf_sticky
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sum0;
  logic [WIDTH-1:0] r_sum1;
  logic [3:0]       r_flags0;
  logic [3:0]       r_flags1;
  logic [15:0]      r_count;
  logic             r_sticky;

  logic             w_push;
  logic             w_pop;
  logic             w_load0;
  logic             w_load1;
  logic             w_shift;
  logic             w_flag_z;
  logic             w_flag_n;
  logic             w_flag_v;
  logic [3:0]       w_flags_in;

  // Flags are captured with the entry so they always describe the stored sum.
  assign w_flag_z   = (sum == '0);
  assign w_flag_n   = sum[WIDTH-1];
  assign w_flag_v   = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
  assign w_flags_in = {cout, w_flag_v, w_flag_n, w_flag_z};

  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load0     = 1'b0;
    w_load1     = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_nxt = S_ONE;
          w_load0     = 1'b1;
        end
      end
      S_ONE: begin
        case ({w_push, w_pop})
          2'b10: begin
            w_state_nxt = S_FULL;
            w_load1     = 1'b1;
          end
          2'b01: begin
            w_state_nxt = S_EMPTY;
          end
          2'b11: begin
            w_state_nxt = S_ONE;
            w_load0     = 1'b1;
          end
          default: begin
            w_state_nxt = S_ONE;
          end
        endcase
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt = S_ONE;
          w_shift     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_sum0   <= '0;
      r_sum1   <= '0;
      r_flags0 <= '0;
      r_flags1 <= '0;
      r_count  <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load0) begin
        r_sum0   <= sum;
        r_flags0 <= w_flags_in;
      end else if (w_shift) begin
        r_sum0   <= r_sum1;
        r_flags0 <= r_flags1;
      end
      if (w_load1) begin
        r_sum1   <= sum;
        r_flags1 <= w_flags_in;
      end
      if (w_pop) begin
        r_count <= r_count + 16'd1;
      end
      // A new overflow in the same cycle as a clear must not be lost.
      if (w_push && w_flag_v) begin
        r_sticky <= 1'b1;
      end else if (clr_sticky) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign out_sum      = out_valid ? r_sum0 : '0;
  assign out_flags    = out_valid ? r_flags0 : 4'b0000;
  assign result_count = r_count;
  assign ovf_sticky   = r_sticky;

endmodule

// File: tb/tb_adder_result_stage_32_bit.sv
// Scoreboard bench for adder_result_stage_32_bit: the driver queues expected
// {flags,sum} on each accepted input, a negedge monitor pops and compares on delivery.
module tb_adder_result_stage_32_bit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          a_msb;
  logic          b_msb;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic [3:0]    out_flags;
  logic [15:0]   result_count;
  logic          clr_sticky;
  logic          ovf_sticky;

  int            checks = 0;
  int            failures = 0;
  logic [35:0]   exp_q[$];
  logic [15:0]   m_count = 16'd0;
  logic          m_sticky = 1'b0;
  bit            armed = 1'b0;

  always #5 clk = ~clk;

  adder_result_stage_32_bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sum         (sum),
    .cout        (cout),
    .a_msb       (a_msb),
    .b_msb       (b_msb),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_flags   (out_flags),
    .result_count(result_count),
    .clr_sticky  (clr_sticky),
    .ovf_sticky  (ovf_sticky)
  );

  // Reference flags straight from the arithmetic definitions.
  function automatic logic [3:0] ref_flags(logic [W-1:0] s, logic c, logic a, logic b);
    logic z, n, v;
    z = (s == 0);
    n = s[W-1];
    v = (a == b) && (n != a);
    return {c, v, n, z};
  endfunction

  task automatic check(string name, logic [35:0] act, logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs with the model and retires delivered results.
  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", {35'd0, in_ready}, {35'd0, exp_q.size() < 2});
      check("out_valid", {35'd0, out_valid}, {35'd0, exp_q.size() > 0});
      check("result_count", {20'd0, result_count}, {20'd0, m_count});
      check("ovf_sticky", {35'd0, ovf_sticky}, {35'd0, m_sticky});
      if (exp_q.size() > 0) begin
        check("out_sum", {4'd0, out_sum}, {4'd0, exp_q[0][31:0]});
        check("out_flags", {32'd0, out_flags}, {32'd0, exp_q[0][35:32]});
      end else begin
        check("idle_sum", {4'd0, out_sum}, 36'd0);
        check("idle_flags", {32'd0, out_flags}, 36'd0);
      end
      if (rst) begin
        exp_q.delete();
        m_count = 16'd0;
      end else if (exp_q.size() > 0 && out_ready) begin
        void'(exp_q.pop_front());
        m_count = m_count + 16'd1;
      end
    end
  end

  // One clock of stimulus; starts and ends 1 time unit after a rising edge.
  task automatic step(bit v, logic [W-1:0] s, bit c, bit a, bit b, bit ordy, bit clr, bit r);
    logic [3:0] fl;
    in_valid   = v;
    sum        = s;
    cout       = c;
    a_msb      = a;
    b_msb      = b;
    out_ready  = ordy;
    clr_sticky = clr;
    rst        = r;
    @(negedge clk);
    #1;
    if (r) begin
      m_sticky = 1'b0;
    end else begin
      fl = ref_flags(s, c, a, b);
      if (v && in_ready) exp_q.push_back({fl, s});
      if (v && in_ready && fl[2]) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit ordy);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rs;
    @(posedge clk);
    #1;
    step(1'b0, 32'h0, 0, 0, 0, 0, 0, 1'b1);
    step(1'b1, 32'h5, 0, 0, 0, 1, 0, 1'b1);
    armed = 1'b1;

    step(1'b1, 32'h0025002B, 0, 0, 0, 1, 0, 0);
    check("basic_valid", {35'd0, out_valid}, 36'd1);
    check("basic_sum", {4'd0, out_sum}, {4'd0, 32'h0025002B});
    check("basic_flags", {32'd0, out_flags}, {32'd0, 4'b0000});
    idle(1'b1);
    check("basic_count", {20'd0, result_count}, 36'd1);

    step(1'b1, 32'h0, 1, 1, 0, 1, 0, 0);
    check("cz_flags", {32'd0, out_flags}, {32'd0, 4'b1001});
    check("cz_sticky", {35'd0, ovf_sticky}, 36'd0);
    idle(1'b1);

    step(1'b1, 32'h80000000, 0, 0, 0, 1, 0, 0);
    check("vn_flags", {32'd0, out_flags}, {32'd0, 4'b0110});
    check("vn_sticky", {35'd0, ovf_sticky}, 36'd1);
    step(1'b1, 32'h80000000, 0, 0, 0, 1, 1'b1, 0);
    check("set_beats_clr", {35'd0, ovf_sticky}, 36'd1);
    step(1'b0, 32'h0, 0, 0, 0, 1, 1'b1, 0);
    check("clr_sticky", {35'd0, ovf_sticky}, 36'd0);

    step(1'b0, 32'h0, 0, 0, 0, 0, 0, 1'b1);
    step(1'b1, 32'h1, 0, 0, 0, 0, 0, 0);
    step(1'b1, 32'h2, 0, 0, 0, 0, 0, 0);
    check("full_in_ready", {35'd0, in_ready}, 36'd0);
    step(1'b1, 32'h3, 0, 0, 0, 0, 0, 0);
    check("full_head", {4'd0, out_sum}, 36'h1);
    idle(1'b1);
    check("order_second", {4'd0, out_sum}, 36'h2);
    idle(1'b1);
    check("drain_count", {20'd0, result_count}, 36'd2);
    check("drain_empty", {35'd0, out_valid}, 36'd0);

    step(1'b1, 32'h80000000, 0, 0, 0, 0, 0, 0);
    step(1'b1, 32'h7FFFFFFF, 0, 1, 1, 0, 0, 0);
    step(1'b1, 32'h9, 0, 0, 0, 1, 0, 1'b1);
    check("rst_valid", {35'd0, out_valid}, 36'd0);
    check("rst_ready", {35'd0, in_ready}, 36'd1);
    check("rst_count", {20'd0, result_count}, 36'd0);
    check("rst_sticky", {35'd0, ovf_sticky}, 36'd0);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0: rs = 32'h0;
        1: rs = 32'h80000000;
        default: rs = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, rs, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
    end

    step(1'b0, 32'h0, 0, 0, 0, 1, 0, 1'b1);
    for (int i = 0; i < 70000 && m_count != 16'hFFFF; i++) begin
      step(1'b1, $urandom, 0, 0, 0, 1, 0, 0);
    end
    check("wrap_reach", {20'd0, result_count}, {20'd0, 16'hFFFF});
    idle(1'b1);
    check("wrap_zero", {20'd0, result_count}, 36'd0);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
